// File: rtl/emb_decoder.sv
// ============================================================================
//  Module   : emb_decoder
//  Purpose  : Per-token argmax of dot products against the W_emb table.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

`ifndef N
`define N 4
`endif
`ifndef EMB_DIM
`define EMB_DIM 8
`endif
`ifndef N_LEN_W
`define N_LEN_W 8
`endif
`ifndef CHAR_NUM
`define CHAR_NUM 16
`endif
`ifndef CHAR_LEN
`define CHAR_LEN 4
`endif
`ifndef DATA_N
`define DATA_N 4
`endif

module emb_decoder #(
    parameter int ADDR_WIDTH = 10,
    parameter int ACC_WIDTH  = 2*`N_LEN_W+8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               run,
    input  logic [`N*`EMB_DIM*`N_LEN_W-1:0]    d,
    output logic                               valid,
    output logic [`N*`CHAR_LEN-1:0]            q,
    output logic [ADDR_WIDTH-1:0]              raddr,
    input  logic [`DATA_N*`N_LEN_W-1:0]        rdata
);
    localparam int c_ROW_W = `EMB_DIM/`DATA_N;
    localparam int c_DEPTH = `CHAR_NUM*c_ROW_W;
    localparam int c_WW    = (c_ROW_W > 1) ? $clog2(c_ROW_W) : 1;
    localparam int c_RW    = (`CHAR_NUM > 1) ? $clog2(`CHAR_NUM) : 1;
    localparam int c_TW    = (`N > 1) ? $clog2(`N) : 1;
    localparam int c_PW    = 2*`N_LEN_W;
    localparam int c_QL    = `CHAR_LEN;

    localparam logic [c_WW-1:0]       c_WORD_LAST = c_WW'(c_ROW_W-1);
    localparam logic [c_RW-1:0]       c_ROW_LAST  = c_RW'(`CHAR_NUM-1);
    localparam logic [c_TW-1:0]       c_TOK_LAST  = c_TW'(`N-1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_LAST = ADDR_WIDTH'(c_DEPTH-1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic [`N*`EMB_DIM*`N_LEN_W-1:0] r_dbuf;
    logic                            r_issue;
    logic [c_WW-1:0]                 r_word;
    logic [c_RW-1:0]                 r_row;
    logic [c_TW-1:0]                 r_tok;
    logic [ADDR_WIDTH-1:0]           r_addr;
    logic [ADDR_WIDTH-1:0]           r_raddr;

    // Stage A: address on the RAM port; stage B: rdata valid; stage M: accumulated.
    logic                            r_a_v, r_a_first, r_a_last;
    logic [c_WW-1:0]                 r_a_word;
    logic [c_RW-1:0]                 r_a_row;
    logic [c_TW-1:0]                 r_a_tok;
    logic                            r_b_v, r_b_first, r_b_last;
    logic [c_WW-1:0]                 r_b_word;
    logic [c_RW-1:0]                 r_b_row;
    logic [c_TW-1:0]                 r_b_tok;
    logic                            r_m_v, r_m_last;
    logic [c_RW-1:0]                 r_m_row;
    logic [c_TW-1:0]                 r_m_tok;

    logic signed [ACC_WIDTH-1:0]     r_acc;
    logic signed [ACC_WIDTH-1:0]     r_best_score;
    logic [c_RW-1:0]                 r_best_idx;
    logic [`N*`CHAR_LEN-1:0]         r_q;
    logic                            r_valid;

    logic signed [ACC_WIDTH-1:0]     w_sum;
    logic signed [c_PW-1:0]          w_prod;
    logic                            w_row_done;
    logic                            w_take;
    logic [c_RW-1:0]                 w_new_idx;
    logic signed [ACC_WIDTH-1:0]     w_new_score;
    logic                            w_final;

    assign valid = r_valid;
    assign q     = r_q;
    assign raddr = r_raddr;

    always_comb begin
        w_sum  = '0;
        w_prod = '0;
        for (int i = 0; i < `DATA_N; i++) begin
            w_prod = $signed(r_dbuf[((int'(r_b_tok)*`EMB_DIM) + int'(r_b_word)*`DATA_N + i)*`N_LEN_W +: `N_LEN_W])
                   * $signed(rdata[i*`N_LEN_W +: `N_LEN_W]);
            w_sum  = w_sum + ACC_WIDTH'(w_prod);
        end
    end

    // Row 0 seeds the running best; later rows win only on a strictly larger score.
    assign w_row_done  = r_m_v && r_m_last;
    assign w_take      = (r_m_row == '0) || (r_acc > r_best_score);
    assign w_new_idx   = w_take ? r_m_row : r_best_idx;
    assign w_new_score = w_take ? r_acc : r_best_score;
    assign w_final     = w_row_done && (r_m_row == c_ROW_LAST) && (r_m_tok == c_TOK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (run) w_state_nxt = S_SCAN;
            S_SCAN: begin
                if (!run)         w_state_nxt = S_IDLE;
                else if (w_final) w_state_nxt = S_DONE;
            end
            S_DONE:  if (!run) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbuf       <= '0;
            r_issue      <= 1'b0;
            r_word       <= '0;
            r_row        <= '0;
            r_tok        <= '0;
            r_addr       <= '0;
            r_raddr      <= '0;
            r_a_v        <= 1'b0;
            r_a_first    <= 1'b0;
            r_a_last     <= 1'b0;
            r_a_word     <= '0;
            r_a_row      <= '0;
            r_a_tok      <= '0;
            r_b_v        <= 1'b0;
            r_b_first    <= 1'b0;
            r_b_last     <= 1'b0;
            r_b_word     <= '0;
            r_b_row      <= '0;
            r_b_tok      <= '0;
            r_m_v        <= 1'b0;
            r_m_last     <= 1'b0;
            r_m_row      <= '0;
            r_m_tok      <= '0;
            r_acc        <= '0;
            r_best_score <= '0;
            r_best_idx   <= '0;
            r_q          <= '0;
            r_valid      <= 1'b0;
        end else if (r_state == S_SCAN && run) begin
            if (r_issue) begin
                r_raddr   <= r_addr;
                r_a_v     <= 1'b1;
                r_a_first <= (r_word == '0);
                r_a_last  <= (r_word == c_WORD_LAST);
                r_a_word  <= r_word;
                r_a_row   <= r_row;
                r_a_tok   <= r_tok;
                r_addr    <= (r_addr == c_ADDR_LAST) ? '0 : r_addr + 1'b1;
                if (r_word != c_WORD_LAST) begin
                    r_word <= r_word + 1'b1;
                end else begin
                    r_word <= '0;
                    if (r_row != c_ROW_LAST) begin
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_row <= '0;
                        if (r_tok != c_TOK_LAST) r_tok <= r_tok + 1'b1;
                        else                     r_issue <= 1'b0;
                    end
                end
            end else begin
                r_raddr <= '0;
                r_a_v   <= 1'b0;
            end

            r_b_v     <= r_a_v;
            r_b_first <= r_a_first;
            r_b_last  <= r_a_last;
            r_b_word  <= r_a_word;
            r_b_row   <= r_a_row;
            r_b_tok   <= r_a_tok;

            if (r_b_v) r_acc <= r_b_first ? w_sum : r_acc + w_sum;
            r_m_v    <= r_b_v;
            r_m_last <= r_b_last;
            r_m_row  <= r_b_row;
            r_m_tok  <= r_b_tok;

            if (w_row_done) begin
                r_best_score <= w_new_score;
                r_best_idx   <= w_new_idx;
                if (r_m_row == c_ROW_LAST) r_q[int'(r_m_tok)*c_QL +: c_QL] <= c_QL'(w_new_idx);
            end
            if (w_final) r_valid <= 1'b1;
        end else begin
            // IDLE, DONE, or an aborted scan: the pipeline holds nothing.
            r_issue <= 1'b0;
            r_raddr <= '0;
            r_a_v   <= 1'b0;
            r_b_v   <= 1'b0;
            r_m_v   <= 1'b0;
            r_word  <= '0;
            r_row   <= '0;
            r_tok   <= '0;
            r_addr  <= '0;
            r_valid <= (r_state == S_DONE) && run;
            if (r_state == S_IDLE && run) begin
                r_dbuf  <= d;
                r_issue <= 1'b1;
                r_acc   <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_emb_decoder.sv
// ============================================================================
//  Module   : tb_emb_decoder
//  Purpose  : Table-driven and randomized checks of emb_decoder vs. a model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

`ifndef N
`define N 4
`endif
`ifndef EMB_DIM
`define EMB_DIM 8
`endif
`ifndef N_LEN_W
`define N_LEN_W 8
`endif
`ifndef CHAR_NUM
`define CHAR_NUM 16
`endif
`ifndef CHAR_LEN
`define CHAR_LEN 4
`endif
`ifndef DATA_N
`define DATA_N 4
`endif

module tb_emb_decoder;
    localparam int AW    = 10;
    localparam int ACCW  = 2*`N_LEN_W+8;
    localparam int NT    = `N;
    localparam int EMB   = `EMB_DIM;
    localparam int NL    = `N_LEN_W;
    localparam int CN    = `CHAR_NUM;
    localparam int CL    = `CHAR_LEN;
    localparam int DN    = `DATA_N;
    localparam int ROW_W = EMB/DN;
    localparam int DEPTH = CN*ROW_W;
    localparam int T     = NT*DEPTH;
    localparam int QW    = NT*CL;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   run = 1'b0;
    logic [NT*EMB*NL-1:0]   d_in = '0;
    logic                   valid;
    logic [QW-1:0]          q;
    logic [AW-1:0]          raddr;
    logic [DN*NL-1:0]       rdata = '0;

    logic [DN*NL-1:0]       mem [0:(1<<AW)-1];
    int                     W [CN][EMB];
    int                     D [NT][EMB];

    int total = 0;
    int bad   = 0;

    emb_decoder #(.ADDR_WIDTH(AW), .ACC_WIDTH(ACCW)) dut (
        .clk(clk), .rst(rst), .run(run), .d(d_in),
        .valid(valid), .q(q), .raddr(raddr), .rdata(rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rdata <= mem[raddr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer dot products and first-maximum argmax.
    function automatic logic [QW-1:0] model_q();
        logic [QW-1:0] res;
        int best, bs, s;
        res = '0;
        for (int t = 0; t < NT; t++) begin
            best = 0;
            bs   = 0;
            for (int r = 0; r < CN; r++) begin
                s = 0;
                for (int e = 0; e < EMB; e++) s += D[t][e] * W[r][e];
                if (r == 0 || s > bs) begin
                    bs   = s;
                    best = r;
                end
            end
            res[t*CL +: CL] = CL'(best);
        end
        return res;
    endfunction

    task automatic pack();
        for (int a = 0; a < (1<<AW); a++) mem[a] = '0;
        for (int r = 0; r < CN; r++)
            for (int e = 0; e < EMB; e++)
                mem[r*ROW_W + e/DN][(e%DN)*NL +: NL] = NL'(W[r][e]);
        for (int t = 0; t < NT; t++)
            for (int e = 0; e < EMB; e++)
                d_in[(t*EMB+e)*NL +: NL] = NL'(D[t][e]);
    endtask

    // kw: 0 ramp, 1 zeros, 2 rows 5/9 tied max, 3 identity-like; kd: 0 +1, 1 -1, 2 one-hot
    task automatic set_pattern(input int kw, input int kd);
        for (int r = 0; r < CN; r++)
            for (int e = 0; e < EMB; e++)
                case (kw)
                    0:       W[r][e] = r;
                    1:       W[r][e] = 0;
                    2:       W[r][e] = (r == 5 || r == 9) ? 100 : r % 5;
                    default: W[r][e] = (e == r % EMB) ? 127 : 0;
                endcase
        for (int t = 0; t < NT; t++)
            for (int e = 0; e < EMB; e++)
                case (kd)
                    0:       D[t][e] = 1;
                    1:       D[t][e] = -1;
                    default: D[t][e] = (e == t) ? 1 : 0;
                endcase
        pack();
    endtask

    task automatic set_random();
        for (int r = 0; r < CN; r++)
            for (int e = 0; e < EMB; e++) W[r][e] = int'($urandom_range(255)) - 128;
        for (int t = 0; t < NT; t++)
            for (int e = 0; e < EMB; e++) D[t][e] = int'($urandom_range(255)) - 128;
        pack();
    endtask

    // Entered just after an edge with run=0 and the DUT idle; raises run, so
    // the next edge is E0. n counts edges after E0.
    task automatic run_scan(input int abort_at, output int lat, output int addr_err, output bit seen);
        lat      = -1;
        addr_err = 0;
        seen     = 1'b0;
        run      = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= T + 40; n++) begin
            @(posedge clk); #1;
            if (n <= T && raddr !== AW'((n-1) % DEPTH)) addr_err++;
            if (valid) begin
                seen = 1'b1;
                if (lat < 0) lat = n;
                if (abort_at == 0) break;
            end
            if (abort_at == n) run = 1'b0;
            if (abort_at > 0 && n >= abort_at + 8) break;
        end
    endtask

    task automatic release_run();
        run = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        int            kw;
        int            kd;
        logic [QW-1:0] exp_q;
    } vec_t;

    initial begin
        vec_t          vecs [5];
        int            lat, aerr;
        bit            seen;
        logic [QW-1:0] prev_q, new_q, exp_q;

        vecs[0] = '{0, 0, {NT{CL'(CN-1)}}};
        vecs[1] = '{0, 1, '0};
        vecs[2] = '{1, 0, '0};
        vecs[3] = '{2, 0, {NT{CL'(5)}}};
        vecs[4] = '{3, 2, '0};
        for (int t = 0; t < NT; t++) vecs[4].exp_q[t*CL +: CL] = CL'(t);

        for (int a = 0; a < (1<<AW); a++) mem[a] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_q",     32'(q),     32'd0);
        check("reset_raddr", 32'(raddr), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            set_pattern(vecs[i].kw, vecs[i].kd);
            run_scan(0, lat, aerr, seen);
            check($sformatf("vec%0d_latency", i), 32'(lat),  32'(T+3));
            check($sformatf("vec%0d_raddr", i),   32'(aerr), 32'd0);
            check($sformatf("vec%0d_q", i),       32'(q),    32'(vecs[i].exp_q));
            release_run();
            check($sformatf("vec%0d_valid_drop", i), 32'(valid), 32'd0);
        end
        prev_q = vecs[4].exp_q;

        for (int k = 0; k < 4; k++) begin
            set_random();
            exp_q = model_q();
            run_scan(0, lat, aerr, seen);
            check($sformatf("rand%0d_latency", k), 32'(lat), 32'(T+3));
            check($sformatf("rand%0d_q", k),       32'(q),   32'(exp_q));
            release_run();
            prev_q = exp_q;
        end

        // Abort midway through token 1: only slice 0 has been rewritten.
        set_random();
        new_q = model_q();
        exp_q = prev_q;
        exp_q[CL-1:0] = new_q[CL-1:0];
        run_scan(DEPTH + DEPTH/2, lat, aerr, seen);
        check("abort_no_valid", 32'(seen),  32'd0);
        check("abort_q",        32'(q),     32'(exp_q));
        check("abort_raddr",    32'(raddr), 32'd0);
        run = 1'b0;
        run_scan(0, lat, aerr, seen);
        check("restart_latency", 32'(lat),  32'(T+3));
        check("restart_raddr",   32'(aerr), 32'd0);
        check("restart_q",       32'(q),    32'(new_q));

        // Reset while DONE with run still held high.
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_done_valid", 32'(valid), 32'd0);
        check("rst_done_q",     32'(q),     32'd0);
        check("rst_done_raddr", 32'(raddr), 32'd0);
        rst = 1'b0;
        run = 1'b0;
        @(posedge clk); #1;

        // Restart right on the edge after DONE->IDLE.
        set_pattern(0, 0);
        run_scan(0, lat, aerr, seen);
        run = 1'b0;
        @(posedge clk); #1;
        check("back2back_idle", 32'(valid), 32'd0);
        run_scan(0, lat, aerr, seen);
        check("back2back_latency", 32'(lat), 32'(T+3));
        check("back2back_q",       32'(q),   32'({NT{CL'(CN-1)}}));
        release_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
